fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NREQ, 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, 8, data width; matches the async FIFO WIDTH.
REQ-003 Parameter BURST, 4, max consecutive pushes per grant (1..16).
REQ-004 wclk  input  1  write-side clock; the only clock of the block.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 en  input  1  arbitration enable; 0 blocks new grants, the current grant finishes.
REQ-007 req_valid  input  NREQ  per-requester data-valid.
REQ-008 req_data  input  NREQ*WIDTH  packed requester data; slice i belongs to requester i.
REQ-009 req_ready  output  NREQ  per-requester accept; a transfer occurs when valid&ready in the same cycle.
REQ-010 gnt  output  NREQ  registered one-hot current owner; all-zero when idle.
REQ-011 push  output  1  FIFO push strobe.
REQ-012 din  output  WIDTH  FIFO write data.
REQ-013 full  input  1  FIFO full flag, wclk domain.

Function
REQ-014 The FSM SHALL have two states, IDLE and BUSY, with registers owner, rr_ptr and cnt (log2(BURST)+1 bits).
REQ-015 In IDLE with en=1 and any req_valid, the block SHALL pick the first valid index searching upward from rr_ptr with wrap, then enter BUSY with gnt=onehot(owner) and cnt=0 on the next edge.
REQ-016 In IDLE with en=0 or no req_valid, the block SHALL stay in IDLE with gnt=0.
REQ-017 The block SHALL NOT transfer data in IDLE; arbitration costs exactly one bubble cycle.
REQ-018 In BUSY, req_ready[owner] SHALL equal !full, and every other req_ready bit SHALL be 0.
REQ-019 Push logic is combinational: push=BUSY&req_valid[owner]&!full, and din=req_data[owner] whenever in BUSY.
REQ-020 Each push SHALL increment cnt.
REQ-021 A push with cnt==BURST-1 SHALL return the FSM to IDLE and set rr_ptr=(owner+1) mod NREQ.
REQ-022 In BUSY, req_valid[owner]=0 SHALL return the FSM to IDLE with rr_ptr=(owner+1) mod NREQ, with no push that cycle.
REQ-023 full=1 in BUSY SHALL stall: no push, cnt and owner held, grant kept, even if the stall lasts indefinitely.
REQ-024 push SHALL never assert while full=1, so the FIFO cannot overflow.
REQ-025 Data from a requester SHALL reach the FIFO in its presentation order; the block SHALL NOT reorder or drop data.
REQ-026 en falling in BUSY SHALL NOT abort the grant; the block SHALL return to IDLE only per REQ-021/022.

Reset
REQ-027 On rstn=0 the block SHALL asynchronously enter IDLE with owner=0, rr_ptr=0, cnt=0, gnt=0, push=0 and req_ready=0.
REQ-028 Reset mid-burst SHALL discard the grant and push no data; din content is don't-care while push=0.
REQ-029 Deassertion of rstn is synchronised externally; the first arbitration occurs on the first wclk edge after release.

Structure
REQ-030 The state enum (IDLE, BUSY) SHALL live in the shared package fifo_pkg, alongside the FIFO WIDTH/DEPTH defaults.
REQ-031 One sub-module, rr_pick, SHALL be purely combinational and produce the winner index from req_valid and rr_ptr.
REQ-032 The arbiter SHALL instantiate alongside async_fifo, driving its push/din and consuming its full.

Verification
REQ-033 Single requester: req_valid=4'b0001 with data 0x10..0x17 and BURST=4 -> gnt=0001, pushes 0x10-0x13, one IDLE bubble, re-grant to 0, then pushes 0x14-0x17.
REQ-034 All four valid continuously, full=0 -> grant order 0,1,2,3,0; each grant gives exactly 4 pushes followed by one bubble cycle.
REQ-035 full held high for 5 cycles mid-burst (cnt=2) -> push=0 and gnt unchanged for 5 cycles, then the remaining 2 pushes occur.
REQ-036 Owner 2 drops valid after 1 push -> FSM enters IDLE next cycle, rr_ptr=3, and requester 3 wins over 0 when both are valid.
REQ-037 en=0 during a burst -> burst completes, then gnt stays 0 until en=1.
REQ-038 rstn pulled low mid-burst -> gnt=0, push=0 and req_ready=0 immediately; after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its write-side arbiter.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, with wrap.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int          c;
  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest valid index is assigned last and wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    c    = 0;
    cand = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= NREQ) c = c - NREQ;
      cand = IW'(c);
      if (valid[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter that funnels NREQ valid/ready requesters into one FIFO write port.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = FIFO_WIDTH,
  parameter int BURST = 4
) (
  input  logic                  wclk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       gnt,
  output logic                  push,
  output logic [WIDTH-1:0]      din,
  input  logic                  full
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST) + 1;

  arb_state_t    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            owner_valid;
  logic            last_beat;
  logic [IW-1:0]   next_ptr;
  logic [NREQ-1:0] owner_oh;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign owner_valid = req_valid[owner_q];
  assign last_beat   = (cnt_q == CW'(BURST - 1));
  assign next_ptr    = IW'(wrap_inc(int'(owner_q), NREQ));
  assign owner_oh    = NREQ'(1) << owner_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wclk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (en && pick_any) begin
          state_d = BUSY;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!owner_valid) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (!full) begin
          cnt_d = cnt_q + CW'(1);
          if (last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // gnt decodes straight from flops, so it is glitch-free and changes only on wclk.
  always_comb begin
    gnt       = '0;
    req_ready = '0;
    push      = 1'b0;
    din       = req_data[int'(owner_q)*WIDTH +: WIDTH];
    if (state_q == BUSY) begin
      gnt  = owner_oh;
      push = owner_valid && !full;
      if (!full) req_ready = owner_oh;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomised bench for fifo_wr_arb against a transaction-level model with per-requester data streams.
module tb_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic                  wclk = 1'b0;
  logic                  rstn;
  logic                  en;
  logic                  full;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       gnt;
  logic                  push;
  logic [WIDTH-1:0]      din;

  fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .wclk      (wclk),
    .rstn      (rstn),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .gnt       (gnt),
    .push      (push),
    .din       (din),
    .full      (full)
  );

  always #5 wclk = ~wclk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the port, how many beats it has had, where the next search starts,
  // and how far along each requester's data stream has been consumed.
  bit m_busy;
  int m_owner;
  int m_rr;
  int m_beats;
  int seq [NREQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] data_of(input int r, input int s);
    return WIDTH'((r << 5) | (s & 31));
  endfunction

  task automatic drive_data();
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = data_of(i, seq[i]);
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_rr    = 0;
    m_beats = 0;
  endtask

  task automatic model_advance();
    int w;
    if (!m_busy) begin
      if (en) begin
        w = model_pick();
        if (w >= 0) begin
          m_busy  = 1'b1;
          m_owner = w;
          m_beats = 0;
        end
      end
    end else if (!req_valid[m_owner]) begin
      m_busy = 1'b0;
      m_rr   = (m_owner + 1) % NREQ;
    end else if (!full) begin
      m_beats++;
      seq[m_owner]++;
      if (m_beats == BURST) begin
        m_busy = 1'b0;
        m_rr   = (m_owner + 1) % NREQ;
      end
    end
  endtask

  // One clock: present data, compare on the falling edge, advance the model on the rising edge.
  task automatic step(input string tag);
    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_push;
    drive_data();
    @(negedge wclk);
    exp_gnt  = m_busy ? NREQ'(1 << m_owner) : '0;
    exp_rdy  = (m_busy && !full) ? NREQ'(1 << m_owner) : '0;
    exp_push = m_busy && req_valid[m_owner] && !full;
    check({tag, ":gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ":ready"}, 32'(req_ready), 32'(exp_rdy));
    check({tag, ":push"}, 32'(push), 32'(exp_push));
    if (exp_push) check({tag, ":din"}, 32'(din), 32'(data_of(m_owner, seq[m_owner])));
    @(posedge wclk);
    model_advance();
    #1;
  endtask

  task automatic seek(input string tag, input int owner, input int beats);
    bit reached;
    reached = 1'b0;
    for (int k = 0; k < 40 && !reached; k++) begin
      if (m_busy && (owner < 0 || m_owner == owner) && m_beats == beats) reached = 1'b1;
      else step(tag);
    end
    check({tag, ":reached"}, 32'(reached), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    model_reset();
    rstn      = 1'b0;
    en        = 1'b0;
    full      = 1'b0;
    req_valid = '0;
    drive_data();
    #3;
    check("reset:gnt", 32'(gnt), 32'd0);
    check("reset:push", 32'(push), 32'd0);
    check("reset:ready", 32'(req_ready), 32'd0);
    @(posedge wclk);
    #1 rstn = 1'b1;

    // Lone requester: bursts of BURST separated by one bubble.
    en        = 1'b1;
    req_valid = 4'b0001;
    repeat (11) step("single");

    // Everyone valid: rotation 0,1,2,3,0.
    req_valid = 4'b1111;
    repeat (22) step("rotate");

    // Stall for five cycles after two beats.
    seek("stall_seek", -1, 2);
    full = 1'b1;
    repeat (5) step("stall");
    full = 1'b0;
    repeat (6) step("stall_rel");

    // Owner 2 drops after one push; 3 must beat 0.
    seek("drop_seek", 2, 1);
    req_valid = 4'b1001;
    repeat (3) step("drop");

    // en falls mid-burst: burst finishes, then no new grants.
    req_valid = 4'b1111;
    seek("en_seek", -1, 1);
    en = 1'b0;
    repeat (10) step("en_off");
    en = 1'b1;
    repeat (4) step("en_on");

    repeat (1500) begin
      req_valid = NREQ'($urandom);
      full      = ($urandom % 5) == 0;
      en        = ($urandom % 10) != 0;
      step("rand");
    end

    // Reset mid-burst, then arbitration restarts at requester 0.
    full      = 1'b0;
    en        = 1'b1;
    req_valid = 4'b1111;
    seek("rst_seek", -1, 1);
    rstn = 1'b0;
    #1;
    check("midrst:gnt", 32'(gnt), 32'd0);
    check("midrst:push", 32'(push), 32'd0);
    check("midrst:ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge wclk);
    @(posedge wclk);
    #1 rstn = 1'b1;
    repeat (8) step("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
